// File: rtl/dma_desc_queue.sv
// Two-direction DMA descriptor queue with launchers that pulse start/address/length into the
// duplex AXI-stream DMA. Optional completion interrupt is enabled by defining DMA_DESC_IRQ_EN.
module dma_desc_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     flush,
  input  logic                     desc_valid,
  output logic                     desc_ready,
  input  logic                     desc_dir,
  input  logic [63:0]              desc_addr,
  input  logic [31:0]              desc_len,
  output logic                     start_rx,
  output logic                     start_tx,
  output logic [63:0]              src_addr_rx,
  output logic [63:0]              dst_addr_tx,
  output logic [31:0]              len_pkts_rx,
  output logic [31:0]              len_pkts_tx,
  input  logic                     busy_rx,
  input  logic                     done_rx,
  input  logic                     busy_tx,
  input  logic                     done_tx,
  output logic [$clog2(DEPTH):0]   rx_level,
  output logic [$clog2(DEPTH):0]   tx_level,
  output logic [CNT_W-1:0]         rx_done_cnt,
  output logic [CNT_W-1:0]         tx_done_cnt,
  output logic                     err_zero_len,
  input  logic                     err_clr,
  output logic                     irq,
  input  logic                     irq_ack
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Index 0 is the RX direction, index 1 is TX.
  logic [63:0]      mem_addr [2][DEPTH];
  logic [31:0]      mem_len  [2][DEPTH];
  logic [PTR_W-1:0] wr_ptr   [2];
  logic [PTR_W-1:0] rd_ptr   [2];
  logic [LVL_W-1:0] level    [2];

  state_t           state      [2];
  logic             wait_first [2];
  logic             start_q    [2];
  logic [CNT_W-1:0] done_cnt   [2];

  logic             busy      [2];
  logic             done      [2];
  logic             full      [2];
  logic             nonempty  [2];
  logic             push      [2];
  logic             pop       [2];
  logic             launch    [2];
  logic             zero_pop  [2];
  logic             inc       [2];
  logic [63:0]      head_addr [2];
  logic [31:0]      head_len  [2];

  assign busy[0] = busy_rx;
  assign busy[1] = busy_tx;
  assign done[0] = done_rx;
  assign done[1] = done_tx;

  // Ready looks only at registered occupancy, so a same-cycle pop never frees a full FIFO.
  assign desc_ready = !flush && !(desc_dir ? full[1] : full[0]);
  assign push[0]    = desc_valid && desc_ready && !desc_dir;
  assign push[1]    = desc_valid && desc_ready && desc_dir;

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      full[d]      = (level[d] == LVL_W'(DEPTH));
      nonempty[d]  = (level[d] != '0);
      head_addr[d] = nonempty[d] ? mem_addr[d][rd_ptr[d]] : '0;
      head_len[d]  = nonempty[d] ? mem_len[d][rd_ptr[d]]  : '0;
      // A flush in IDLE wins over a launch so the FSM never starts a dropped head.
      launch[d]    = (state[d] == IDLE) && nonempty[d] && enable && !busy[d] && !flush
                     && (head_len[d] != '0);
      zero_pop[d]  = (state[d] == IDLE) && nonempty[d] && enable && !busy[d] && !flush
                     && (head_len[d] == '0);
      inc[d]       = (state[d] == WAIT) && !wait_first[d] && done[d];
      pop[d]       = zero_pop[d] || inc[d];
    end
  end

  always_ff @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (push[d]) begin
        mem_addr[d][wr_ptr[d]] <= desc_addr;
        mem_len[d][wr_ptr[d]]  <= desc_len;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        wr_ptr[d] <= '0;
        rd_ptr[d] <= '0;
        level[d]  <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (pop[d]) rd_ptr[d] <= rd_ptr[d] + 1'b1;
        if (flush) begin
          // An in-flight head survives the flush; everything behind it is discarded.
          if (state[d] != IDLE) begin
            wr_ptr[d] <= rd_ptr[d] + 1'b1;
            level[d]  <= pop[d] ? LVL_W'(0) : LVL_W'(1);
          end else begin
            wr_ptr[d] <= rd_ptr[d];
            level[d]  <= '0;
          end
        end else begin
          if (push[d]) wr_ptr[d] <= wr_ptr[d] + 1'b1;
          level[d] <= level[d] + LVL_W'(push[d]) - LVL_W'(pop[d]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        state[d]      <= IDLE;
        wait_first[d] <= 1'b0;
        start_q[d]    <= 1'b0;
        done_cnt[d]   <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        case (state[d])
          IDLE: begin
            if (launch[d]) begin
              state[d]   <= START;
              start_q[d] <= 1'b1;
            end
          end
          START: begin
            start_q[d]    <= 1'b0;
            wait_first[d] <= 1'b1;
            state[d]      <= WAIT;
          end
          WAIT: begin
            // The first WAIT cycle may still see the previous transfer's sticky done.
            wait_first[d] <= 1'b0;
            if (inc[d]) begin
              done_cnt[d] <= done_cnt[d] + 1'b1;
              state[d]    <= IDLE;
            end
          end
          default: begin
            state[d]   <= IDLE;
            start_q[d] <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_zero_len <= 1'b0;
    end else if (zero_pop[0] || zero_pop[1]) begin
      err_zero_len <= 1'b1;
    end else if (err_clr) begin
      err_zero_len <= 1'b0;
    end
  end

`ifdef DMA_DESC_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b0;
    end else if (inc[0] || inc[1]) begin
      irq <= 1'b1;
    end else if (irq_ack) begin
      irq <= 1'b0;
    end
  end
`else
  logic unused_irq_ack;
  assign unused_irq_ack = irq_ack;
  assign irq = 1'b0;
`endif

  assign start_rx    = start_q[0];
  assign start_tx    = start_q[1];
  assign src_addr_rx = head_addr[0];
  assign dst_addr_tx = head_addr[1];
  assign len_pkts_rx = head_len[0];
  assign len_pkts_tx = head_len[1];
  assign rx_level    = level[0];
  assign tx_level    = level[1];
  assign rx_done_cnt = done_cnt[0];
  assign tx_done_cnt = done_cnt[1];

endmodule

// File: tb/tb_dma_desc_queue.sv
// Bench for dma_desc_queue: directed scenarios plus randomized traffic against a DMA model and a
// descriptor-order scoreboard.
module tb_dma_desc_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
`ifdef DMA_DESC_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  typedef struct {
    logic [63:0] addr;
    logic [31:0] len;
  } desc_t;

  logic clk, rst, enable, flush, desc_valid, desc_ready, desc_dir;
  logic [63:0] desc_addr, src_addr_rx, dst_addr_tx;
  logic [31:0] desc_len, len_pkts_rx, len_pkts_tx;
  logic start_rx, start_tx, busy_rx, done_rx, busy_tx, done_tx;
  logic [$clog2(DEPTH):0] rx_level, tx_level;
  logic [CNT_W-1:0] rx_done_cnt, tx_done_cnt;
  logic err_zero_len, err_clr, irq, irq_ack;

  int checks = 0;
  int errors = 0;
  desc_t exp_rx[$];
  desc_t exp_tx[$];
  int exp_cnt_rx = 0, exp_cnt_tx = 0;
  logic err_exp = 1'b0;
  logic act_rx = 1'b0, act_tx = 1'b0;
  int starts_rx = 0, starts_tx = 0;
  int lat_fix_rx = 0;

  dma_desc_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_dir(desc_dir),
    .desc_addr(desc_addr), .desc_len(desc_len),
    .start_rx(start_rx), .start_tx(start_tx),
    .src_addr_rx(src_addr_rx), .dst_addr_tx(dst_addr_tx),
    .len_pkts_rx(len_pkts_rx), .len_pkts_tx(len_pkts_tx),
    .busy_rx(busy_rx), .done_rx(done_rx), .busy_tx(busy_tx), .done_tx(done_tx),
    .rx_level(rx_level), .tx_level(tx_level),
    .rx_done_cnt(rx_done_cnt), .tx_done_cnt(tx_done_cnt),
    .err_zero_len(err_zero_len), .err_clr(err_clr),
    .irq(irq), .irq_ack(irq_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic dir, input logic [63:0] a, input logic [31:0] l,
                      output logic acc);
    desc_valid = 1'b1;
    desc_dir   = dir;
    desc_addr  = a;
    desc_len   = l;
    #1;
    acc = desc_ready;
    @(posedge clk);
    #1;
    desc_valid = 1'b0;
    if (acc) begin
      if (l == 32'd0) err_exp = 1'b1;
      else if (dir) begin exp_tx.push_back('{a, l}); exp_cnt_tx++; end
      else begin exp_rx.push_back('{a, l}); exp_cnt_rx++; end
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_rx.size() != 0 || exp_tx.size() != 0 || rx_level != 0 || tx_level != 0 ||
            act_rx || act_tx) && n < 3000) begin
      tick();
      n++;
    end
    check({tag, "_drain_in_time"}, 64'(n < 3000), 64'd1);
    check({tag, "_rx_cnt"}, 64'(rx_done_cnt), 64'(exp_cnt_rx % (1 << CNT_W)));
    check({tag, "_tx_cnt"}, 64'(tx_done_cnt), 64'(exp_cnt_tx % (1 << CNT_W)));
    check({tag, "_rx_level"}, 64'(rx_level), 64'd0);
    check({tag, "_tx_level"}, 64'(tx_level), 64'd0);
    check({tag, "_err"}, 64'(err_zero_len), 64'(err_exp));
  endtask

  task automatic irq_round(input string tag);
    check({tag, "_irq_pending"}, 64'(irq), 64'(IRQ_ON));
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check({tag, "_irq_acked"}, 64'(irq), 64'd0);
  endtask

  // RX side of the DMA: done is sticky, stays stale one cycle past start, then clears.
  initial begin : rx_model
    desc_t d;
    int lat;
    busy_rx = 1'b0;
    done_rx = 1'b0;
    forever begin
      tick();
      if (start_rx && !rst) begin
        act_rx = 1'b1;
        starts_rx++;
        check("rx_start_expected", 64'(exp_rx.size() != 0), 64'd1);
        if (exp_rx.size() != 0) begin
          d = exp_rx.pop_front();
          check("rx_addr", src_addr_rx, d.addr);
          check("rx_len", 64'(len_pkts_rx), 64'(d.len));
        end
        lat = (lat_fix_rx != 0) ? lat_fix_rx : int'($urandom_range(1, 5));
        tick();
        check("rx_start_width", 64'(start_rx), 64'd0);
        busy_rx = 1'b1;
        tick();
        done_rx = 1'b0;
        repeat (lat) tick();
        done_rx = 1'b1;
        busy_rx = 1'b0;
        act_rx  = 1'b0;
      end
    end
  end

  initial begin : tx_model
    desc_t d;
    int lat;
    busy_tx = 1'b0;
    done_tx = 1'b0;
    forever begin
      tick();
      if (start_tx && !rst) begin
        act_tx = 1'b1;
        starts_tx++;
        check("tx_start_expected", 64'(exp_tx.size() != 0), 64'd1);
        if (exp_tx.size() != 0) begin
          d = exp_tx.pop_front();
          check("tx_addr", dst_addr_tx, d.addr);
          check("tx_len", 64'(len_pkts_tx), 64'(d.len));
        end
        lat = int'($urandom_range(1, 7));
        tick();
        check("tx_start_width", 64'(start_tx), 64'd0);
        busy_tx = 1'b1;
        tick();
        done_tx = 1'b0;
        repeat (lat) tick();
        done_tx = 1'b1;
        busy_tx = 1'b0;
        act_tx  = 1'b0;
      end
    end
  end

  initial begin : main
    logic acc;
    int saved;
    rst = 1'b1; enable = 1'b1; flush = 1'b0; desc_valid = 1'b0; desc_dir = 1'b0;
    desc_addr = '0; desc_len = '0; err_clr = 1'b0; irq_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_start_rx", 64'(start_rx), 64'd0);
    check("rst_start_tx", 64'(start_tx), 64'd0);
    check("rst_src_addr_rx", src_addr_rx, 64'd0);
    check("rst_len_pkts_tx", 64'(len_pkts_tx), 64'd0);
    check("rst_desc_ready", 64'(desc_ready), 64'd1);
    check("rst_rx_level", 64'(rx_level), 64'd0);
    check("rst_tx_cnt", 64'(tx_done_cnt), 64'd0);
    check("rst_err", 64'(err_zero_len), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    tick();

    // Single RX descriptor: start appears two cycles after the push.
    push(1'b0, 64'h1000, 32'd3, acc);
    check("rx1_accepted", 64'(acc), 64'd1);
    check("rx1_t1_no_start", 64'(start_rx), 64'd0);
    check("rx1_t1_level", 64'(rx_level), 64'd1);
    check("rx1_t1_head_addr", src_addr_rx, 64'h1000);
    tick();
    check("rx1_t2_start", 64'(start_rx), 64'd1);
    check("rx1_t2_len", 64'(len_pkts_rx), 64'd3);
    drain("rx1");
    irq_round("rx1");

    // TX fills to DEPTH while launching is held off.
    enable = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      push(1'b1, 64'h2000 + 64'(i) * 64'h40, 32'(i + 1), acc);
      check("tx_fill_accepted", 64'(acc), 64'd1);
    end
    check("tx_full_level", 64'(tx_level), 64'(DEPTH));
    push(1'b1, 64'hdead, 32'd9, acc);
    check("tx_full_not_ready", 64'(acc), 64'd0);
    desc_dir = 1'b0;
    #1;
    check("rx_ready_while_tx_full", 64'(desc_ready), 64'd1);
    tick();
    enable = 1'b1;
    drain("tx4");
    irq_round("tx4");

    // Zero-length descriptor is retired without a start; the next one runs.
    push(1'b0, 64'h3000, 32'd0, acc);
    push(1'b0, 64'h3100, 32'd2, acc);
    drain("zero");
    check("zero_err_set", 64'(err_zero_len), 64'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    err_exp = 1'b0;
    check("zero_err_cleared", 64'(err_zero_len), 64'd0);
    irq_round("zero");

    // Flush during WAIT of the first of three RX descriptors, with a same-cycle push.
    lat_fix_rx = 12;
    push(1'b0, 64'h4000, 32'd5, acc);
    push(1'b0, 64'h4100, 32'd6, acc);
    push(1'b0, 64'h4200, 32'd7, acc);
    tick();
    tick();
    check("flush_pre_level", 64'(rx_level), 64'd3);
    flush = 1'b1;
    desc_valid = 1'b1;
    desc_dir = 1'b0;
    desc_addr = 64'hbad;
    desc_len = 32'd1;
    #1;
    check("flush_ready_low", 64'(desc_ready), 64'd0);
    tick();
    flush = 1'b0;
    desc_valid = 1'b0;
    check("flush_post_level", 64'(rx_level), 64'd1);
    exp_cnt_rx -= exp_rx.size();
    exp_rx.delete();
    drain("flush");
    saved = starts_rx;
    repeat (30) tick();
    check("flush_no_restart", 64'(starts_rx), 64'(saved));
    lat_fix_rx = 0;
    irq_round("flush");

    // Randomized interleaved RX/TX traffic with enable toggling.
    for (int i = 0; i < 150; i++) begin
      enable = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 3) != 0) begin
        push(1'($urandom_range(0, 1)), {$urandom, $urandom},
             ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 1000)), acc);
      end else begin
        tick();
      end
    end
    enable = 1'b1;
    drain("rand");
    check("rand_rx_started", 64'(starts_rx > 3), 64'd1);
    check("rand_tx_started", 64'(starts_tx > 4), 64'd1);
    irq_round("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
